// File: rtl/memex_load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : memex_load_store_unit_if
// Description : Data-memory bus between the MEMEX load/store unit (master)
//               and the data memory (slave): valid/ready request channel
//               plus a valid-qualified read response channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface memex_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, addr, we, wstrb, wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, addr, we, wstrb, wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/memex_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : memex_load_store_unit
// Description : MEMEX stage of the RV32E core. Runs loads/stores on the data
//               memory bus, stalls the pipeline while an access is in flight
//               and registers the writeback triple for the WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
module memex_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            invalid_MEMEX_i,
  input  logic [3:0]                      rd_MEMEX_i,
  input  logic [31:0]                     alu_result_MEMEX_i,
  input  logic                            regfile_we_MEMEX_i,
  input  logic                            mem_re_MEMEX_i,
  input  logic                            mem_we_MEMEX_i,
  input  logic [1:0]                      mem_size_MEMEX_i,
  input  logic                            mem_unsigned_MEMEX_i,
  input  logic [31:0]                     store_data_MEMEX_i,
  memex_load_store_unit_if.master         dmem,
  output logic                            stall_o,
  output logic [3:0]                      rd_WB_o,
  output logic [31:0]                     wb_data_WB_o,
  output logic                            regfile_we_WB_o,
  output logic                            mem_fault_o
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        tout_q;
  logic [31:0] load_data_q;
  logic [31:0] load_ext_d;
  logic [3:0]  rd_WB_q;
  logic [31:0] wb_data_WB_q;
  logic        regfile_we_WB_q;
  logic        mem_fault_q;

  logic        is_op_d;
  logic        misaligned_d;
  logic        start_d;
  logic [1:0]  lane_d;

  // Classify the instruction sitting in the MEMEX slot
  always_comb begin
    lane_d       = alu_result_MEMEX_i[1:0];
    is_op_d      = (mem_re_MEMEX_i | mem_we_MEMEX_i) & ~invalid_MEMEX_i;
    // size 11 falls into the word check through size[1]
    misaligned_d = is_op_d &
                   (((mem_size_MEMEX_i == 2'b01) & lane_d[0]) |
                    (mem_size_MEMEX_i[1] & (lane_d != 2'b00)));
    start_d      = (state_q == S_IDLE) & is_op_d & ~misaligned_d;
    cnt_d        = cnt_q + 8'd1;
  end

  // Bus request and stall; inputs are held upstream while stalled, so the
  // request fields stay stable through REQ without extra registers
  always_comb begin
    dmem.req_valid = start_d | (state_q == S_REQ);
    stall_o        = start_d | (state_q == S_REQ) | (state_q == S_WAIT_RSP);
    dmem.addr      = {alu_result_MEMEX_i[31:2], 2'b00};
    dmem.we        = mem_we_MEMEX_i;
    dmem.wstrb     = 4'b0000;
    dmem.wdata     = store_data_MEMEX_i;
    case (mem_size_MEMEX_i)
      2'b00: begin
        dmem.wdata = {4{store_data_MEMEX_i[7:0]}};
        if (mem_we_MEMEX_i) dmem.wstrb = 4'b0001 << lane_d;
      end
      2'b01: begin
        dmem.wdata = {2{store_data_MEMEX_i[15:0]}};
        if (mem_we_MEMEX_i) dmem.wstrb = lane_d[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (mem_we_MEMEX_i) dmem.wstrb = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel   = dmem.rsp_rdata[{lane_d, 3'b000} +: 8];
    half_sel   = dmem.rsp_rdata[{lane_d[1], 4'b0000} +: 16];
    load_ext_d = dmem.rsp_rdata;
    case (mem_size_MEMEX_i)
      2'b00:   load_ext_d = mem_unsigned_MEMEX_i ? {24'd0, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext_d = mem_unsigned_MEMEX_i ? {16'd0, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
      default: load_ext_d = dmem.rsp_rdata;
    endcase
  end

  // Access FSM, timeout counter and WB-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      tout_q          <= 1'b0;
      load_data_q     <= 32'd0;
      rd_WB_q         <= 4'd0;
      wb_data_WB_q    <= 32'd0;
      regfile_we_WB_q <= 1'b0;
      mem_fault_q     <= 1'b0;
    end else begin
      mem_fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            cnt_q  <= 8'd0;
            tout_q <= 1'b0;
            if (dmem.req_ready) state_q <= mem_we_MEMEX_i ? S_DONE : S_WAIT_RSP;
            else                state_q <= S_REQ;
          end else begin
            // Non-memory, bubble or misaligned: retire this cycle
            rd_WB_q         <= rd_MEMEX_i;
            wb_data_WB_q    <= alu_result_MEMEX_i;
            regfile_we_WB_q <= regfile_we_MEMEX_i & ~invalid_MEMEX_i & ~misaligned_d;
            mem_fault_q     <= misaligned_d;
          end
        end
        S_REQ: begin
          if (dmem.req_ready) state_q <= mem_we_MEMEX_i ? S_DONE : S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (dmem.rsp_valid) begin
            load_data_q <= load_ext_d;
            state_q     <= S_DONE;
          end else if (cnt_d == TIMEOUT_LIMIT) begin
            tout_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          // S_DONE: stall drops for one cycle and the access retires
          rd_WB_q         <= rd_MEMEX_i;
          wb_data_WB_q    <= (mem_re_MEMEX_i & ~tout_q) ? load_data_q : alu_result_MEMEX_i;
          regfile_we_WB_q <= mem_re_MEMEX_i & regfile_we_MEMEX_i & ~tout_q;
          mem_fault_q     <= tout_q;
          state_q         <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_WB_o         = rd_WB_q;
  assign wb_data_WB_o    = wb_data_WB_q;
  assign regfile_we_WB_o = regfile_we_WB_q;
  assign mem_fault_o     = mem_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_memex_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_memex_load_store_unit
// Description : Self-checking bench for memex_load_store_unit. A driver issues
//               instructions and plays the memory; expected writebacks go to a
//               scoreboard queue that a monitor pops when the WB regs update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memex_load_store_unit;

  logic        clk;
  logic        rst;
  logic        invalid_MEMEX;
  logic [3:0]  rd_MEMEX;
  logic [31:0] alu_result_MEMEX;
  logic        regfile_we_MEMEX;
  logic        mem_re_MEMEX;
  logic        mem_we_MEMEX;
  logic [1:0]  mem_size_MEMEX;
  logic        mem_unsigned_MEMEX;
  logic [31:0] store_data_MEMEX;
  logic        stall;
  logic [3:0]  rd_WB;
  logic [31:0] wb_data_WB;
  logic        regfile_we_WB;
  logic        mem_fault;

  memex_load_store_unit_if dif ();

  memex_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .invalid_MEMEX_i      (invalid_MEMEX),
    .rd_MEMEX_i           (rd_MEMEX),
    .alu_result_MEMEX_i   (alu_result_MEMEX),
    .regfile_we_MEMEX_i   (regfile_we_MEMEX),
    .mem_re_MEMEX_i       (mem_re_MEMEX),
    .mem_we_MEMEX_i       (mem_we_MEMEX),
    .mem_size_MEMEX_i     (mem_size_MEMEX),
    .mem_unsigned_MEMEX_i (mem_unsigned_MEMEX),
    .store_data_MEMEX_i   (store_data_MEMEX),
    .dmem                 (dif.master),
    .stall_o              (stall),
    .rd_WB_o              (rd_WB),
    .wb_data_WB_o         (wb_data_WB),
    .regfile_we_WB_o      (regfile_we_WB),
    .mem_fault_o          (mem_fault)
  );

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic issue_live = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: WB regs update on the edge ending a non-stalled live cycle
  initial begin
    logic smp;
    exp_t e;
    forever begin
      @(negedge clk);
      smp = issue_live && !stall && !rst;
      @(posedge clk);
      #1;
      if (smp) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("we_WB", {31'd0, regfile_we_WB}, {31'd0, e.we});
          check_val("mem_fault", {31'd0, mem_fault}, {31'd0, e.fault});
          if (e.we) begin
            check_val("rd_WB", {28'd0, rd_WB}, {28'd0, e.rd});
            check_val("wb_data", wb_data_WB, e.data);
          end
        end
      end else if (!rst) begin
        check_val("fault_quiet", {31'd0, mem_fault}, 32'd0);
      end
    end
  end

  // Issue one instruction (caller is 1 time unit after a posedge) and act as memory
  task automatic run_op(
    input logic re, input logic we, input logic [1:0] sz, input logic uns, input logic inv,
    input logic [3:0] rd, input logic rwe, input logic [31:0] addr, input logic [31:0] sdata,
    input int rdy_lat, input int rsp_at, input logic [31:0] rdata,
    input int exp_stall, input int exp_req, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
    input logic [31:0] exp_data, input logic exp_we, input logic exp_fault);
    int stalls, reqs, waits, n;
    bit acc, done;
    mem_re_MEMEX = re;  mem_we_MEMEX = we;  mem_size_MEMEX = sz;
    mem_unsigned_MEMEX = uns;  invalid_MEMEX = inv;  rd_MEMEX = rd;
    regfile_we_MEMEX = rwe;  alu_result_MEMEX = addr;  store_data_MEMEX = sdata;
    issue_live = 1'b1;
    sb.push_back(exp_t'{rd, exp_data, exp_we, exp_fault});
    stalls = 0; reqs = 0; waits = 0; n = 0; acc = 0; done = 0;
    while (!done && n < 40) begin
      dif.req_ready = !acc && (reqs >= rdy_lat);
      dif.rsp_valid = acc && (rsp_at > 0) && (waits == rsp_at);
      dif.rsp_rdata = dif.rsp_valid ? rdata : 32'h5A5A_5A5A;
      #1;
      if (dif.req_valid) begin
        check_val("req_addr", dif.addr, {addr[31:2], 2'b00});
        check_val("req_we", {31'd0, dif.we}, {31'd0, we});
        check_val("req_wstrb", {28'd0, dif.wstrb}, {28'd0, exp_strb});
        if (we) check_val("req_wdata", dif.wdata, exp_wdata);
        reqs++;
        if (dif.req_ready) acc = 1;
      end
      if (stall) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
      if (acc) waits++;
      n++;
    end
    if (!done) check_val("op_timeout_bound", 32'd0, 32'd1);
    check_val("stall_cycles", 32'(stalls), 32'(exp_stall));
    check_val("req_cycles", 32'(reqs), 32'(exp_req));
  endtask

  initial begin
    rst = 1'b1;
    invalid_MEMEX = 1'b0; rd_MEMEX = 4'd0; alu_result_MEMEX = 32'd0;
    regfile_we_MEMEX = 1'b0; mem_re_MEMEX = 1'b0; mem_we_MEMEX = 1'b0;
    mem_size_MEMEX = 2'b00; mem_unsigned_MEMEX = 1'b0; store_data_MEMEX = 32'd0;
    dif.req_ready = 1'b0; dif.rsp_valid = 1'b0; dif.rsp_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rd_WB", {28'd0, rd_WB}, 32'd0);
    check_val("rst_wb_data", wb_data_WB, 32'd0);
    check_val("rst_we_WB", {31'd0, regfile_we_WB}, 32'd0);
    check_val("rst_fault", {31'd0, mem_fault}, 32'd0);
    check_val("rst_req_valid", {31'd0, dif.req_valid}, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    //     re we sz    u  i  rd    rwe addr          sdata         rl rsp rdata         st rq strb     wdata         exp_data      we fault
    run_op(1, 0, 2'b10, 0, 0, 4'd3, 1, 32'h0000_0100, 32'd0,        0, 2, 32'hDEAD_BEEF, 3, 1, 4'b0000, 32'd0,        32'hDEAD_BEEF, 1, 0);
    run_op(1, 0, 2'b00, 0, 0, 4'd4, 1, 32'h0000_0103, 32'd0,        0, 1, 32'h80FF_FF00, 2, 1, 4'b0000, 32'd0,        32'hFFFF_FF80, 1, 0);
    run_op(1, 0, 2'b00, 1, 0, 4'd5, 1, 32'h0000_0103, 32'd0,        0, 1, 32'h80FF_FF00, 2, 1, 4'b0000, 32'd0,        32'h0000_0080, 1, 0);
    run_op(1, 0, 2'b00, 0, 0, 4'd6, 1, 32'h0000_0101, 32'd0,        0, 1, 32'h1234_7F56, 2, 1, 4'b0000, 32'd0,        32'h0000_007F, 1, 0);
    run_op(1, 0, 2'b01, 0, 0, 4'd7, 1, 32'h0000_0102, 32'd0,        0, 1, 32'h8001_1234, 2, 1, 4'b0000, 32'd0,        32'hFFFF_8001, 1, 0);
    run_op(1, 0, 2'b01, 1, 0, 4'd8, 1, 32'h0000_0100, 32'd0,        0, 3, 32'h8001_9234, 4, 1, 4'b0000, 32'd0,        32'h0000_9234, 1, 0);
    run_op(0, 1, 2'b01, 0, 0, 4'd9, 0, 32'h0000_0022, 32'h1234_ABCD, 3, 0, 32'd0,        4, 4, 4'b1100, 32'hABCD_ABCD, 32'd0,        0, 0);
    run_op(0, 1, 2'b00, 0, 0, 4'd1, 0, 32'h0000_0031, 32'h0000_00EE, 0, 0, 32'd0,        1, 1, 4'b0010, 32'hEEEE_EEEE, 32'd0,        0, 0);
    run_op(0, 1, 2'b10, 0, 0, 4'd2, 0, 32'h0000_0040, 32'hCAFE_BABE, 1, 0, 32'd0,        2, 2, 4'b1111, 32'hCAFE_BABE, 32'd0,        0, 0);
    run_op(1, 0, 2'b10, 0, 0, 4'd3, 1, 32'h0000_0101, 32'd0,        0, 0, 32'd0,        0, 0, 4'b0000, 32'd0,        32'd0,        0, 1);
    run_op(1, 0, 2'b01, 0, 0, 4'd3, 1, 32'h0000_0103, 32'd0,        0, 0, 32'd0,        0, 0, 4'b0000, 32'd0,        32'd0,        0, 1);
    run_op(1, 0, 2'b10, 0, 0, 4'd4, 1, 32'h0000_0080, 32'd0,        0, 0, 32'd0,        5, 1, 4'b0000, 32'd0,        32'd0,        0, 1);
    run_op(0, 0, 2'b00, 0, 0, 4'd5, 1, 32'h0000_1234, 32'd0,        0, 0, 32'd0,        0, 0, 4'b0000, 32'd0,        32'h0000_1234, 1, 0);
    run_op(1, 0, 2'b10, 0, 1, 4'd6, 1, 32'h0000_0101, 32'd0,        0, 0, 32'd0,        0, 0, 4'b0000, 32'd0,        32'd0,        0, 0);
    run_op(1, 0, 2'b11, 0, 0, 4'd7, 1, 32'h0000_000C, 32'd0,        0, 1, 32'h1122_3344, 2, 1, 4'b0000, 32'd0,        32'h1122_3344, 1, 0);
    run_op(1, 0, 2'b10, 0, 0, 4'd8, 1, 32'h0000_0200, 32'd0,        2, 1, 32'h0BAD_F00D, 4, 3, 4'b0000, 32'd0,        32'h0BAD_F00D, 1, 0);

    // Reset in WAIT_RSP, then a late response must be ignored
    mem_re_MEMEX = 1'b1; mem_we_MEMEX = 1'b0; mem_size_MEMEX = 2'b10; invalid_MEMEX = 1'b0;
    rd_MEMEX = 4'd9; regfile_we_MEMEX = 1'b1; alu_result_MEMEX = 32'h0000_0300;
    dif.req_ready = 1'b1; dif.rsp_valid = 1'b0;
    issue_live = 1'b1;
    @(posedge clk);
    #1;
    dif.req_ready = 1'b0;
    check_val("wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    issue_live = 1'b0;
    mem_re_MEMEX = 1'b0; rd_MEMEX = 4'd0; regfile_we_MEMEX = 1'b0; alu_result_MEMEX = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dif.rsp_valid = 1'b1;
    dif.rsp_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    dif.rsp_valid = 1'b0;
    check_val("late_rsp_we_WB", {31'd0, regfile_we_WB}, 32'd0);
    check_val("late_rsp_wb_data", wb_data_WB, 32'd0);
    check_val("late_rsp_rd_WB", {28'd0, rd_WB}, 32'd0);
    check_val("late_rsp_stall", {31'd0, stall}, 32'd0);
    check_val("late_rsp_req", {31'd0, dif.req_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_val("late_rsp_wb_data2", wb_data_WB, 32'd0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
